// File: rtl/odyssey_video_pkg.sv
// Shared types, default raster timing and helpers for the Odyssey video timing stage.
package odyssey_video_pkg;

  localparam int DEF_PIX_DIV      = 4;
  localparam int DEF_H_TOTAL      = 318;
  localparam int DEF_H_ACTIVE     = 256;
  localparam int DEF_H_SYNC_START = 270;
  localparam int DEF_H_SYNC_LEN   = 24;
  localparam int DEF_V_TOTAL      = 262;
  localparam int DEF_V_ACTIVE     = 240;
  localparam int DEF_V_SYNC_START = 244;
  localparam int DEF_V_SYNC_LEN   = 3;

  typedef logic [8:0] raster_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } spot_pos_t;

  // Signed joystick reading (-128..127) to unsigned screen offset (0..255, 0x80 = centre)
  function automatic logic [7:0] to_unsigned_pos(input logic [7:0] a);
    return {~a[7], a[6:0]};
  endfunction

  // Compared at 10 bits so that a window ending exactly at 512 is still representable
  function automatic logic in_window(input raster_t val, input int start, input int len);
    return ({1'b0, val} >= 10'(start)) && ({1'b0, val} < 10'(start + len));
  endfunction

endpackage

// File: rtl/odyssey_pix_ce.sv
// Pixel clock enable: one registered clk-wide pulse every DIV clks.
module odyssey_pix_ce
  import odyssey_video_pkg::*;
#(
  parameter int DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_next;

  always_comb begin
    div_next = (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
  end

  // ce is registered from the next divider value so it is high exactly while div_cnt == DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      ce      <= 1'b0;
    end else begin
      div_cnt <= div_next;
      ce      <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/odyssey_video_timing.sv
// Odyssey raster timing: h/v counters, syncs, blanking, frame strobe and per-frame joystick latch.
// Define ODYSSEY_CSYNC_EN to add a registered composite sync output csync = hsync ^ vsync.
module odyssey_video_timing
  import odyssey_video_pkg::*;
#(
  parameter int PIX_DIV      = DEF_PIX_DIV,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] p1_ax,
  input  logic [7:0] p1_ay,
  input  logic [7:0] p2_ax,
  input  logic [7:0] p2_ay,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       frame_start,
  output logic [7:0] p1_x,
  output logic [7:0] p1_y,
  output logic [7:0] p2_x,
  output logic [7:0] p2_y
`ifdef ODYSSEY_CSYNC_EN
 ,output logic       csync
`endif
);

  if (PIX_DIV < 1) begin : g_bad_div
    $error("odyssey_video_timing: PIX_DIV must be at least 1");
  end
  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
    $error("odyssey_video_timing: H_TOTAL and V_TOTAL must not exceed 512");
  end
  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_sync
    $error("odyssey_video_timing: sync window extends past the line/frame total");
  end
  if (H_ACTIVE >= H_SYNC_START || V_ACTIVE >= V_SYNC_START) begin : g_bad_active
    $error("odyssey_video_timing: active region must end before sync starts");
  end

  localparam raster_t H_LAST = raster_t'(H_TOTAL - 1);
  localparam raster_t V_LAST = raster_t'(V_TOTAL - 1);
  localparam raster_t H_ACT  = raster_t'(H_ACTIVE);
  localparam raster_t V_ACT  = raster_t'(V_ACTIVE);

  raster_t   h_next;
  raster_t   v_next;
  logic      h_wrap;
  logic      v_wrap;
  logic      hblank_next;
  logic      vblank_next;
  logic      hsync_next;
  logic      vsync_next;
  logic      latch_pos;
  spot_pos_t p1_pos;
  spot_pos_t p2_pos;

  odyssey_pix_ce #(
    .DIV (PIX_DIV)
  ) u_pix_ce (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix)
  );

  // Everything is derived from the next raster position so registered flags track the counters
  always_comb begin
    h_wrap      = (hcount == H_LAST);
    v_wrap      = (vcount == V_LAST);
    h_next      = h_wrap ? '0 : hcount + raster_t'(1);
    v_next      = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + raster_t'(1);
    end
    hblank_next = (h_next >= H_ACT);
    vblank_next = (v_next >= V_ACT);
    hsync_next  = in_window(h_next, H_SYNC_START, H_SYNC_LEN);
    vsync_next  = in_window(v_next, V_SYNC_START, V_SYNC_LEN);
    latch_pos   = ce_pix && (h_next == '0) && (v_next == V_ACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce_pix && (h_next == '0) && (v_next == '0);
      if (ce_pix) begin
        hcount <= h_next;
        vcount <= v_next;
        hsync  <= hsync_next;
        vsync  <= vsync_next;
        hblank <= hblank_next;
        vblank <= vblank_next;
        de     <= ~(hblank_next | vblank_next);
      end
    end
  end

  // Joystick inputs are sampled only at vblank entry so spots hold still for the whole field
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_pos <= '{x: 8'h80, y: 8'h80};
      p2_pos <= '{x: 8'h80, y: 8'h80};
    end else if (latch_pos) begin
      p1_pos <= '{x: to_unsigned_pos(p1_ax), y: to_unsigned_pos(p1_ay)};
      p2_pos <= '{x: to_unsigned_pos(p2_ax), y: to_unsigned_pos(p2_ay)};
    end
  end

  assign p1_x = p1_pos.x;
  assign p1_y = p1_pos.y;
  assign p2_x = p2_pos.x;
  assign p2_y = p2_pos.y;

`ifdef ODYSSEY_CSYNC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csync <= 1'b0;
    end else if (ce_pix) begin
      csync <= hsync_next ^ vsync_next;
    end
  end
`endif

endmodule
